// File: rtl/reg_mst_bridge_if.sv
// Signal bundle around reg_mst_bridge: the command/response handshake on one
// side and the register-slave access bus on the other.
//   master : the bridge itself (accepts commands, returns responses, drives the bus)
//   slave  : everything around it (command source plus the register slave)
interface reg_mst_bridge_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  // command / response side
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // register-slave side
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy, ack_vld, rd_data,
    output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, req_vld, wr_en, rd_en, addr, wr_data
  );

  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy, ack_vld, rd_data,
    input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, req_vld, wr_en, rd_en, addr, wr_data
  );
endinterface

// File: rtl/reg_mst_bridge.sv
// reg_mst_bridge: single-outstanding initiator for a register slave.
// Takes one command over a valid/ready handshake, issues a one-cycle request
// strobe, waits for the slave acknowledge (bounded by TIMEOUT_CYCLES), returns
// the read data or a timeout error, then forces MIN_GAP idle cycles.
// Optional feature: define REG_MST_POSTED_WR_EN to post write responses (the
// response is offered right after the request while the bus is still waiting
// for the acknowledge; a write timeout is then silently dropped).
// All outputs are registered so they are all zero while rstn is low.
module reg_mst_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIN_GAP        = 2
) (
  input  logic              clk,
  input  logic              rstn,
  reg_mst_bridge_if.master  bus,
  output logic              stray_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);

`ifdef REG_MST_POSTED_WR_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RSP  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [2:0]            state_reg, state_next;
  logic [CNT_W-1:0]      wait_cnt_reg, wait_cnt_next;
  logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
  logic                  is_wr_reg, is_wr_next;
  logic                  cmd_rdy_reg, cmd_rdy_next;
  logic                  req_vld_reg, req_vld_next;
  logic                  wr_en_reg, wr_en_next;
  logic                  rd_en_reg, rd_en_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
  logic                  rsp_vld_reg, rsp_vld_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  stray_reg, stray_next;

  logic timeout_hit;
  logic bus_end;
  logic rsp_hs;
  logic posted_wr;

  // The bus phase ends on ack or on the last allowed WAIT cycle; ack has priority.
  assign timeout_hit = (wait_cnt_reg == CNT_LAST);
  assign bus_end     = bus.ack_vld || timeout_hit;
  assign rsp_hs      = rsp_vld_reg && bus.rsp_rdy;
  assign posted_wr   = POSTED_WR && is_wr_reg;

  assign bus.cmd_rdy   = cmd_rdy_reg;
  assign bus.rsp_vld   = rsp_vld_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.req_vld   = req_vld_reg;
  assign bus.wr_en     = wr_en_reg;
  assign bus.rd_en     = rd_en_reg;
  assign bus.addr      = addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign stray_ack     = stray_reg;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    is_wr_next     = is_wr_reg;
    cmd_rdy_next   = cmd_rdy_reg;
    req_vld_next   = req_vld_reg;
    wr_en_next     = wr_en_reg;
    rd_en_next     = rd_en_reg;
    addr_next      = addr_reg;
    wr_data_next   = wr_data_reg;
    rsp_vld_next   = rsp_vld_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    // An ack is only expected while waiting; anywhere else it is flagged (late ack).
    stray_next     = bus.ack_vld && (state_reg != ST_WAIT);

    case (state_reg)
      ST_IDLE: begin
        if (cmd_rdy_reg && bus.cmd_vld) begin
          state_next   = ST_REQ;
          cmd_rdy_next = 1'b0;
          is_wr_next   = bus.cmd_wr;
          req_vld_next = 1'b1;
          wr_en_next   = bus.cmd_wr;
          rd_en_next   = ~bus.cmd_wr;
          addr_next    = bus.cmd_addr;
          wr_data_next = bus.cmd_wdata;
        end else begin
          // Also raises ready on the first cycle after reset release.
          cmd_rdy_next = 1'b1;
        end
      end

      ST_REQ: begin
        state_next    = ST_WAIT;
        req_vld_next  = 1'b0;
        wait_cnt_next = '0;
        if (posted_wr) begin
          // Posted write: acknowledge the command now, the bus keeps waiting.
          rsp_vld_next   = 1'b1;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
        end
      end

      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        if (bus_end) begin
          wr_en_next   = 1'b0;
          rd_en_next   = 1'b0;
          addr_next    = '0;
          wr_data_next = '0;
        end
        if (posted_wr) begin
          // The early response may complete while the bus is still busy.
          if (rsp_hs) begin
            rsp_vld_next = 1'b0;
          end
          if (bus_end) begin
            if (rsp_vld_reg && !bus.rsp_rdy) begin
              state_next = ST_RSP;
            end else begin
              state_next   = ST_GAP;
              gap_cnt_next = '0;
            end
          end
        end else if (bus_end) begin
          state_next     = ST_RSP;
          rsp_vld_next   = 1'b1;
          rsp_rdata_next = (bus.ack_vld && !is_wr_reg) ? bus.rd_data : '0;
          rsp_err_next   = ~bus.ack_vld;
        end
      end

      ST_RSP: begin
        if (bus.rsp_rdy) begin
          state_next     = ST_GAP;
          gap_cnt_next   = '0;
          rsp_vld_next   = 1'b0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next   = ST_IDLE;
          cmd_rdy_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      is_wr_reg     <= 1'b0;
      cmd_rdy_reg   <= 1'b0;
      req_vld_reg   <= 1'b0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      rsp_vld_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      stray_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      is_wr_reg     <= is_wr_next;
      cmd_rdy_reg   <= cmd_rdy_next;
      req_vld_reg   <= req_vld_next;
      wr_en_reg     <= wr_en_next;
      rd_en_reg     <= rd_en_next;
      addr_reg      <= addr_next;
      wr_data_reg   <= wr_data_next;
      rsp_vld_reg   <= rsp_vld_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      stray_reg     <= stray_next;
    end
  end

endmodule

// File: tb/tb_reg_mst_bridge.sv
// Testbench for reg_mst_bridge: table of directed transactions, a short
// reset-in-WAIT sequence and randomized transactions checked against a
// transaction-level model (latencies and results derived from the timing rules).
module tb_reg_mst_bridge;

  localparam int TMO = 8;
  localparam int GAP = 2;
`ifdef REG_MST_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk;
  logic rstn;
  logic stray;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stray_cnt = 0;
  int stray_cyc = -1;
  int txn_no = 0;

  reg_mst_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bif ();

  reg_mst_bridge #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO), .MIN_GAP(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bif.master), .stray_ack(stray)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && stray) begin
      stray_cnt <= stray_cnt + 1;
      stray_cyc <= cyc;
    end
  end

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [31:0] wdata;
    int          ack_at;    // ack driven this many cycles after req_vld (0 = never)
    logic [31:0] rdat;
    int          rdy_dly;   // cycles rsp_rdy is held low once rsp_vld appears
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, got, exp, txn_no);
    end
  endtask

  // Transaction-level result: the ack counts if it lands inside the WAIT window.
  function automatic void model(input bit wr, input int ack_at, input logic [31:0] rdat,
                                output logic [31:0] er, output bit ee);
    bit ack_ok;
    ack_ok = (ack_at >= 1) && (ack_at <= TMO);
    er = (!wr && ack_ok) ? rdat : 32'h0;
    ee = !ack_ok && !(POSTED && wr);
  endfunction

  task automatic do_txn(input bit wr, input logic [63:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat, input int rdy_dly,
                        input logic [31:0] exp_rdata, input bit exp_err);
    int n, r, bk, bcyc, end_k, exp_first, h, exp_ret, s0;
    bit bus_bad, stall_bad;
    logic [31:0] hold_rd, got_rd;
    logic hold_err, got_err;

    txn_no++;
    n = 0;
    while (!bif.cmd_rdy && n < 64) begin tick(); n++; end
    check("cmd_rdy_wait", bif.cmd_rdy, 1'b1);

    bif.cmd_vld = 1'b1; bif.cmd_wr = wr; bif.cmd_addr = a; bif.cmd_wdata = wd;
    tick();
    bif.cmd_vld = 1'b0; bif.cmd_wr = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;

    r     = cyc;
    s0    = stray_cnt;
    bk    = (ack_at >= 1 && ack_at <= TMO) ? ack_at : TMO;
    bcyc  = r + bk;
    end_k = (ack_at > bk + 1) ? ack_at : bk + 1;
    exp_first = (POSTED && wr) ? r + 1 : bcyc + 1;
    got_rd = '0; got_err = 1'b0;

    fork
      begin : slave_side
        bus_bad = 1'b0;
        for (int k = 0; k <= end_k; k++) begin
          if (k <= bk) begin
            if (bif.req_vld !== (k == 0) || bif.addr !== a || bif.wr_data !== wd ||
                bif.wr_en !== wr || bif.rd_en !== ~wr) bus_bad = 1'b1;
          end else if (bif.req_vld || bif.wr_en || bif.rd_en || bif.addr != 0 || bif.wr_data != 0) begin
            bus_bad = 1'b1;
          end
          if (ack_at > 0 && k == ack_at) begin
            bif.ack_vld = 1'b1; bif.rd_data = rdat;
          end else begin
            bif.ack_vld = 1'b0; bif.rd_data = $urandom;
          end
          tick();
        end
        bif.ack_vld = 1'b0;
        check("bus_hold", bus_bad, 1'b0);
      end
      begin : master_side
        n = 0;
        while (!bif.rsp_vld && n < 64) begin tick(); n++; end
        check("rsp_latency", cyc - r, exp_first - r);
        got_rd = bif.rsp_rdata; got_err = bif.rsp_err;
        check("rsp_rdata", got_rd, exp_rdata);
        check("rsp_err", got_err, exp_err);
        hold_rd = bif.rsp_rdata; hold_err = bif.rsp_err; stall_bad = 1'b0;
        for (int j = 0; j <= rdy_dly; j++) begin
          if (!bif.rsp_vld || bif.rsp_rdata !== hold_rd || bif.rsp_err !== hold_err || bif.cmd_rdy)
            stall_bad = 1'b1;
          if (j < rdy_dly) tick();
        end
        check("rsp_stable", stall_bad, 1'b0);
        h = cyc;
        bif.rsp_rdy = 1'b1;
        tick();
        bif.rsp_rdy = 1'b0;
        check("rsp_drop", bif.rsp_vld, 1'b0);
        n = 0;
        while (!bif.cmd_rdy && n < 64) begin tick(); n++; end
        exp_ret = ((h > bcyc) ? h : bcyc) + GAP + 1;
        check("cmd_rdy_return", cyc, exp_ret);
      end
    join
    tick();

    check("stray_count", stray_cnt - s0, (ack_at > TMO) ? 1 : 0);
    if (ack_at > TMO) check("stray_cycle", stray_cyc, r + ack_at + 1);
    $display("txn %0d %s addr=%h ack_at=%0d rdy_dly=%0d rdata=%h err=%0d", txn_no,
             wr ? "WR" : "RD", a, ack_at, rdy_dly, got_rd, got_err);
  endtask

  initial begin
    logic [31:0] er;
    bit ee, wr;
    int ack_at;
    logic [31:0] rdat;
    logic [63:0] a;

    vecs[0] = '{1'b0, 64'h10, 32'h0,        3,       32'h04D200D2, 0, 32'h04D200D2, 1'b0};
    vecs[1] = '{1'b1, 64'h20, 32'hA5A50001, 1,       32'hDEADBEEF, 0, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 64'h30, 32'h0,        0,       32'h11111111, 0, 32'h0,        1'b1};
    vecs[3] = '{1'b0, 64'h40, 32'h0,        TMO + 3, 32'h22222222, 1, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 64'h50, 32'h0,        1,       32'hCAFEF00D, 5, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 64'h60, 32'h0,        TMO,     32'h12345678, 0, 32'h12345678, 1'b0};
    vecs[6] = '{1'b0, 64'h70, 32'h0,        TMO + 1, 32'h87654321, 2, 32'h0,        1'b1};
    vecs[7] = '{1'b1, 64'h80, 32'h5A5A5A5A, TMO,     32'h33333333, 3, 32'h0,        1'b0};
    vecs[8] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 2, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1'b0};

    bif.cmd_vld = 1'b0; bif.cmd_wr = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
    bif.rsp_rdy = 1'b0; bif.ack_vld = 1'b0; bif.rd_data = '0;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    check("reset_rsp_side", |{bif.cmd_rdy, bif.rsp_vld, bif.rsp_err, bif.rsp_rdata}, 1'b0);
    check("reset_bus_side", |{bif.req_vld, bif.wr_en, bif.rd_en, bif.addr, bif.wr_data, stray}, 1'b0);
    rstn = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++)
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at, vecs[i].rdat,
             vecs[i].rdy_dly, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset asserted while waiting for ack
    begin
      int n;
      n = 0;
      while (!bif.cmd_rdy && n < 64) begin tick(); n++; end
      bif.cmd_vld = 1'b1; bif.cmd_wr = 1'b0; bif.cmd_addr = 64'h77;
      tick();
      bif.cmd_vld = 1'b0; bif.cmd_addr = '0;
      tick();
      tick();
      check("wait_before_reset", bif.rd_en, 1'b1);
      rstn = 1'b0;
      #1;
      check("midreset_rsp_side", |{bif.cmd_rdy, bif.rsp_vld, bif.rsp_err, bif.rsp_rdata}, 1'b0);
      check("midreset_bus_side", |{bif.req_vld, bif.wr_en, bif.rd_en, bif.addr, bif.wr_data}, 1'b0);
      tick();
      tick();
      check("midreset_no_rsp", bif.rsp_vld, 1'b0);
      rstn = 1'b1;
      $display("txn - reset applied during WAIT");
      do_txn(1'b0, 64'h90, 32'h0, 2, 32'h0BADBEEF, 1, 32'h0BADBEEF, 1'b0);
    end

    // Randomized transactions against the model
    for (int i = 0; i < 30; i++) begin
      wr     = 1'($urandom_range(0, 1));
      a      = {$urandom, $urandom};
      ack_at = int'($urandom_range(0, 12));
      rdat   = $urandom;
      model(wr, ack_at, rdat, er, ee);
      do_txn(wr, a, $urandom, ack_at, rdat, int'($urandom_range(0, 4)), er, ee);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
